// File: rtl/riscv_pkg.sv
// Shared fetch-path constants and the fetch FSM state type.
package riscv_pkg;

   localparam int unsigned ADDR_WIDTH = 64;
   localparam int unsigned DATA_WIDTH = 32;
   localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_BOOT  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: valid/pc/instr with load and flush; resets to a NOP bubble.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  flush_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] instr_o
);

   logic                  valid_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] instr_q;

   // Flush only drops valid; payload is left as-is since nothing consumes it while invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= INSTR_NOP;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned           CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid_in,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_in,
   output logic [ADDR_WIDTH-1:0] imem_addr_out,
   input  logic [DATA_WIDTH-1:0] imem_instr_in,
   input  logic                  if_ready_in,
   output logic                  if_valid_out,
   output logic [ADDR_WIDTH-1:0] if_pc_out,
   output logic [DATA_WIDTH-1:0] if_instr_out,
   output logic                  fault_out,
   output logic [CNT_WIDTH-1:0]  fetch_count_out
);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  fault_q, fault_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic load;
   logic xfer;
   logic redir_live;
   logic ld_en;
   logic flush;

   assign load       = (state_q == FETCH_RUN) && (!if_valid_out || if_ready_in);
   assign xfer       = if_valid_out && if_ready_in;
   assign redir_live = redirect_valid_in && (state_q != FETCH_FAULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH_BOOT;
         pc_q    <= RESET_VECTOR;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      ld_en   = 1'b0;
      flush   = 1'b0;

      unique case (state_q)
         FETCH_BOOT:  state_d = FETCH_RUN;
         FETCH_RUN: begin
            if (!redir_live && load) begin
               ld_en = 1'b1;
               pc_d  = pc_q + ADDR_WIDTH'(4);
            end
         end
         FETCH_FAULT: ;
         default:     state_d = FETCH_FAULT;
      endcase

      // Redirect overrides both the BOOT exit and any sequential load this cycle.
      if (redir_live) begin
         flush = 1'b1;
         if (redirect_addr_in[1:0] == 2'b00) begin
            pc_d = redirect_addr_in;
         end else begin
            state_d = FETCH_FAULT;
            fault_d = 1'b1;
         end
      end

      cnt_d = cnt_q + (xfer ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
   end

   if_id_reg u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ld_en),
      .flush_i (flush),
      .pc_i    (pc_q),
      .instr_i (imem_instr_in),
      .valid_o (if_valid_out),
      .pc_o    (if_pc_out),
      .instr_o (if_instr_out)
   );

   assign imem_addr_out   = pc_q;
   assign fault_out       = fault_q;
   assign fetch_count_out = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table plus a transfer scoreboard and reset sequences.
module tb_instr_fetch;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid_in = 1'b0;
   logic [63:0] redirect_addr_in  = '0;
   logic [63:0] imem_addr_out;
   logic [31:0] imem_instr_in;
   logic        if_ready_in = 1'b1;
   logic        if_valid_out;
   logic [63:0] if_pc_out;
   logic [31:0] if_instr_out;
   logic        fault_out;
   logic [31:0] fetch_count_out;

   int n_tests = 0;
   int n_fail  = 0;
   bit sb_on   = 1'b0;
   logic [63:0] sb_q[$];

   instr_fetch #(.RESET_VECTOR(64'h0), .CNT_WIDTH(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .redirect_valid_in (redirect_valid_in),
      .redirect_addr_in  (redirect_addr_in),
      .imem_addr_out     (imem_addr_out),
      .imem_instr_in     (imem_instr_in),
      .if_ready_in       (if_ready_in),
      .if_valid_out      (if_valid_out),
      .if_pc_out         (if_pc_out),
      .if_instr_out      (if_instr_out),
      .fault_out         (fault_out),
      .fetch_count_out   (fetch_count_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'h5A00_0003;
   endfunction

   assign imem_instr_in = instr_of(imem_addr_out);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted handshake must match the next expected PC.
   always @(negedge clk) begin
      if (sb_on && !rst && if_valid_out && if_ready_in) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got transfer pc %h expected none", if_pc_out);
         end else begin
            logic [63:0] p;
            p = sb_q.pop_front();
            chk("sb_pc", if_pc_out, p);
            chk("sb_instr", {32'h0, if_instr_out}, {32'h0, instr_of(p)});
         end
      end
   end

   typedef struct {
      logic        ready;
      logic        rv;
      logic [63:0] raddr;
      logic        push;
      logic [63:0] push_pc;
      logic        e_valid;
      logic [63:0] e_pc;
      logic [63:0] e_imem;
      logic        e_fault;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rv, input logic [63:0] ra,
                               input logic pu, input logic [63:0] pp, input logic ev,
                               input logic [63:0] ep, input logic [63:0] ei,
                               input logic ef, input logic [31:0] ec);
      vec_t t;
      t.ready = r; t.rv = rv; t.raddr = ra; t.push = pu; t.push_pc = pp;
      t.e_valid = ev; t.e_pc = ep; t.e_imem = ei; t.e_fault = ef; t.e_cnt = ec;
      return t;
   endfunction

   localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

   vec_t vecs[17];

   initial begin
      //           rdy rv raddr      push pc      valid pc_out  imem     flt cnt
      vecs[0]  = mk(1, 0, 64'h0,     0, 64'h0,     0, 64'h0,   64'h0,   0, 0);
      vecs[1]  = mk(1, 0, 64'h0,     0, 64'h0,     1, 64'h0,   64'h4,   0, 0);
      vecs[2]  = mk(1, 0, 64'h0,     1, 64'h0,     1, 64'h4,   64'h8,   0, 1);
      vecs[3]  = mk(1, 0, 64'h0,     1, 64'h4,     1, 64'h8,   64'hC,   0, 2);
      vecs[4]  = mk(0, 0, 64'h0,     0, 64'h0,     1, 64'h8,   64'hC,   0, 2);
      vecs[5]  = mk(0, 0, 64'h0,     0, 64'h0,     1, 64'h8,   64'hC,   0, 2);
      vecs[6]  = mk(0, 0, 64'h0,     0, 64'h0,     1, 64'h8,   64'hC,   0, 2);
      vecs[7]  = mk(1, 0, 64'h0,     1, 64'h8,     1, 64'hC,   64'h10,  0, 3);
      vecs[8]  = mk(1, 1, 64'h100,   1, 64'hC,     0, 64'hC,   64'h100, 0, 4);
      vecs[9]  = mk(1, 0, 64'h0,     0, 64'h0,     1, 64'h100, 64'h104, 0, 4);
      vecs[10] = mk(1, 1, TOP,       1, 64'h100,   0, 64'h100, TOP,     0, 5);
      vecs[11] = mk(1, 0, 64'h0,     0, 64'h0,     1, TOP,     64'h0,   0, 5);
      vecs[12] = mk(1, 0, 64'h0,     1, TOP,       1, 64'h0,   64'h4,   0, 6);
      vecs[13] = mk(0, 1, 64'h102,   0, 64'h0,     0, 64'h0,   64'h4,   1, 6);
      vecs[14] = mk(1, 1, 64'h200,   0, 64'h0,     0, 64'h0,   64'h4,   1, 6);
      vecs[15] = mk(0, 0, 64'h0,     0, 64'h0,     0, 64'h0,   64'h4,   1, 6);
      vecs[16] = mk(1, 0, 64'h0,     0, 64'h0,     0, 64'h0,   64'h4,   1, 6);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'h0, if_valid_out}, 64'h0);
      chk("rst_pc", if_pc_out, 64'h0);
      chk("rst_instr", {32'h0, if_instr_out}, {32'h0, INSTR_NOP});
      chk("rst_imem", imem_addr_out, 64'h0);
      chk("rst_fault", {63'h0, fault_out}, 64'h0);
      chk("rst_cnt", {32'h0, fetch_count_out}, 64'h0);
      rst   = 1'b0;
      sb_on = 1'b1;

      for (int i = 0; i < 17; i++) begin
         if_ready_in       = vecs[i].ready;
         redirect_valid_in = vecs[i].rv;
         redirect_addr_in  = vecs[i].raddr;
         if (vecs[i].push) sb_q.push_back(vecs[i].push_pc);
         tick();
         chk($sformatf("v%0d_valid", i), {63'h0, if_valid_out}, {63'h0, vecs[i].e_valid});
         chk($sformatf("v%0d_imem", i), imem_addr_out, vecs[i].e_imem);
         chk($sformatf("v%0d_fault", i), {63'h0, fault_out}, {63'h0, vecs[i].e_fault});
         chk($sformatf("v%0d_cnt", i), {32'h0, fetch_count_out}, {32'h0, vecs[i].e_cnt});
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_pc", i), if_pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), {32'h0, if_instr_out},
                {32'h0, instr_of(vecs[i].e_pc)});
         end
      end
      redirect_valid_in = 1'b0;
      sb_on = 1'b0;
      chk("sb_drained", 64'(sb_q.size()), 64'h0);

      // Reset clears the sticky fault and restarts fetch at the reset vector
      rst = 1'b1;
      #1;
      chk("rst2_fault", {63'h0, fault_out}, 64'h0);
      chk("rst2_imem", imem_addr_out, 64'h0);
      tick();
      rst = 1'b0;
      if_ready_in = 1'b1;
      tick();
      chk("boot2_valid", {63'h0, if_valid_out}, 64'h0);
      tick();
      chk("run2_pc0", if_pc_out, 64'h0);
      chk("run2_valid", {63'h0, if_valid_out}, 64'h1);
      tick();
      tick();
      chk("run2_pc8", if_pc_out, 64'h8);
      chk("run2_cnt", {32'h0, fetch_count_out}, 64'h2);
      if_ready_in = 1'b0;
      tick();
      tick();
      chk("bp_pc", if_pc_out, 64'h8);
      chk("bp_imem", imem_addr_out, 64'hC);

      // Asynchronous reset mid-cycle during backpressure
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", {63'h0, if_valid_out}, 64'h0);
      chk("arst_pc", if_pc_out, 64'h0);
      chk("arst_instr", {32'h0, if_instr_out}, {32'h0, INSTR_NOP});
      chk("arst_imem", imem_addr_out, 64'h0);
      chk("arst_cnt", {32'h0, fetch_count_out}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected end by 100000");
      $fatal(1, "timeout");
   end

endmodule
